// File: rtl/sized_data_memory.sv
// sized_data_memory
//   Byte-addressable, big-endian data memory with byte/half/word access,
//   sign/zero extension on loads, alignment and range fault detection, and a
//   valid/ready request/response handshake with configurable latency.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   req_valid/ready     request handshake (accepted when both high)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 reserved (faults)
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid/ready    response handshake
//   resp_rdata          load result (0 for stores and faults)
//   resp_error          access faulted
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; store commits / load snapshot on accept
// WAIT  | counting out the remaining access latency
// RESP  | response presented, held until resp_ready

module sized_data_memory #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_error
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              error_q, error_d;

    logic [7:0]        mem_q [DEPTH_BYTES];

    logic              accept;
    logic              fault;
    logic [1:0]        nbytes_m1;
    logic [ADDR_W:0]   last_addr;
    logic [IDX_W-1:0]  idx;
    logic [3:0][7:0]   rd_byte;
    logic [31:0]       load_data;
    logic [3:0]        lane_we;
    logic [3:0][7:0]   lane_wb;

    // Decode, fault check and big-endian load assembly
    always_comb begin
        nbytes_m1 = 2'd0;
        case (req_size)
            2'b00:   nbytes_m1 = 2'd0;
            2'b01:   nbytes_m1 = 2'd1;
            default: nbytes_m1 = 2'd3;
        endcase

        // One extra bit so the last byte address cannot wrap past ADDR_W
        last_addr = {1'b0, req_addr} + (ADDR_W + 1)'(nbytes_m1);

        fault = (req_size == 2'b11)
             || (req_size == 2'b01 && req_addr[0])
             || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
             || (last_addr >= DEPTH_EXT);

        idx = req_addr[IDX_W-1:0];
        for (int k = 0; k < 4; k++) begin
            // Index wraps modulo depth; only matters for faulting accesses,
            // whose data is discarded
            rd_byte[k] = mem_q[idx + IDX_W'(k)];
        end

        load_data = 32'd0;
        case (req_size)
            2'b00: load_data = {{24{~req_unsigned & rd_byte[0][7]}}, rd_byte[0]};
            2'b01: load_data = {{16{~req_unsigned & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
            2'b10: load_data = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
            default: load_data = 32'd0;
        endcase
    end

    // Store lanes: lane k targets address idx+k, most significant byte first
    always_comb begin
        lane_we = 4'b0000;
        lane_wb = '0;
        if (accept && req_write && !fault) begin
            case (req_size)
                2'b00: begin
                    lane_we    = 4'b0001;
                    lane_wb[0] = req_wdata[7:0];
                end
                2'b01: begin
                    lane_we    = 4'b0011;
                    lane_wb[0] = req_wdata[15:8];
                    lane_wb[1] = req_wdata[7:0];
                end
                2'b10: begin
                    lane_we    = 4'b1111;
                    lane_wb[0] = req_wdata[31:24];
                    lane_wb[1] = req_wdata[23:16];
                    lane_wb[2] = req_wdata[15:8];
                    lane_wb[3] = req_wdata[7:0];
                end
                default: lane_we = 4'b0000;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    error_d = fault;
                    rdata_d = (fault || req_write) ? 32'd0 : load_data;
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Storage is not reset; reset only blocks a coincident store
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_we[k]) begin
                    mem_q[idx + IDX_W'(k)] <= lane_wb[k];
                end
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule

// File: tb/tb_sized_data_memory.sv
module tb_sized_data_memory;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;
    logic        last_err;
    logic [7:0]  ref_mem [DEPTH];

    always #5 clk = ~clk;

    sized_data_memory #(
        .DEPTH_BYTES(DEPTH),
        .LATENCY    (LAT),
        .ADDR_W     (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error)
    );

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: byte array, plain arithmetic on the access rules
    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] exp_rd, output logic exp_err);
        int          n;
        longint      last;
        logic [31:0] v;
        n       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        last    = longint'({32'd0, a}) + longint'(n - 1);
        exp_err = (sz == 2'b11) || ((a % 32'(n)) != 0) || (last >= longint'(DEPTH));
        exp_rd  = 32'd0;
        if (exp_err) return;
        if (w) begin
            for (int i = 0; i < n; i++)
                ref_mem[a + 32'(i)] = 8'(d >> (8 * (n - 1 - i)));
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++)
                v = (v << 8) | {24'd0, ref_mem[a + 32'(i)]};
            if (!u && n < 4 && v[8 * n - 1])
                v = v | ~((32'd1 << (8 * n)) - 32'd1);
            exp_rd = v;
        end
    endfunction

    // Called at #1 after a rising edge with the DUT idle
    task automatic op(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      input int hold, input string tag);
        logic [31:0] er;
        logic        ee;
        int          n;
        model(w, sz, u, a, d, er, ee);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_size  = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(LAT));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, " hold_ready"}, 32'(req_ready), 32'd0);
            chk({tag, " hold_rdata"}, resp_rdata, er);
            chk({tag, " hold_error"}, 32'(resp_error), 32'(ee));
        end
        chk({tag, " rdata"}, resp_rdata, er);
        chk({tag, " error"}, 32'(resp_error), 32'(ee));
        last_rd    = resp_rdata;
        last_err   = resp_error;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, " idle_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] er;
        logic        ee;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        int          nb;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_error", 32'(resp_error), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH / 4; i++)
            op(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 0, "init");

        op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, "st_w_10");
        chk("st_w_10 const_rdata", last_rd, 32'd0);
        op(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5, "ld_w_10_backpressure");
        chk("ld_w_10 const", last_rd, 32'hDEADBEEF);
        chk("ld_w_10 const_err", 32'(last_err), 32'd0);
        op(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 0, "ld_bu_13");
        chk("ld_bu_13 const", last_rd, 32'h000000EF);
        op(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 0, "ld_b_10");
        chk("ld_b_10 const", last_rd, 32'hFFFFFFDE);
        op(1'b0, 2'b00, 1'b1, 32'h10, 32'd0, 0, "ld_bu_10");
        chk("ld_bu_10 const", last_rd, 32'h000000DE);
        op(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 0, "ld_h_12");
        chk("ld_h_12 const", last_rd, 32'hFFFFBEEF);
        op(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 0, "ld_hu_12");
        chk("ld_hu_12 const", last_rd, 32'h0000BEEF);
        op(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 0, "st_b_11");
        op(1'b0, 2'b10, 1'b1, 32'h10, 32'd0, 0, "ld_w_10_after_sb");
        chk("ld_w_10_after_sb const", last_rd, 32'hDE55BEEF);
        op(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 0, "ld_w_0c_neighbour");
        op(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 0, "ld_w_14_neighbour");

        op(1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, 0, "fault_st_w_12");
        chk("fault_st_w_12 const_err", 32'(last_err), 32'd1);
        op(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0, "fault_st_w_12 readback");
        chk("fault_st_w_12 readback const", last_rd, 32'hDE55BEEF);
        op(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 0, "fault_st_w_12 readback14");
        op(1'b0, 2'b01, 1'b0, 32'h13, 32'd0, 0, "fault_ld_h_13");
        chk("fault_ld_h_13 const_err", 32'(last_err), 32'd1);
        chk("fault_ld_h_13 const_rd", last_rd, 32'd0);
        op(1'b1, 2'b11, 1'b0, 32'h10, 32'h22222222, 0, "fault_size11");
        chk("fault_size11 const_err", 32'(last_err), 32'd1);
        op(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0, "fault_size11 readback");
        chk("fault_size11 readback const", last_rd, 32'hDE55BEEF);
        op(1'b0, 2'b10, 1'b0, 32'h3FE, 32'd0, 0, "fault_ld_w_3fe");
        chk("fault_ld_w_3fe const_err", 32'(last_err), 32'd1);
        op(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'd0, 0, "fault_ld_b_ffffffff");
        chk("fault_ld_b_ffffffff const_err", 32'(last_err), 32'd1);
        op(1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, 0, "ld_w_3fc_edge");
        chk("ld_w_3fc_edge const_err", 32'(last_err), 32'd0);

        // Reset while in WAIT, with a competing request held during reset
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        model(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, er, ee);
        @(posedge clk); #1;
        chk("rst_wait in_wait_ready", 32'(req_ready), 32'd0);
        chk("rst_wait in_wait_valid", 32'(resp_valid), 32'd0);
        reset = 1'b1;
        req_addr = 32'h84; req_wdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_wait valid_during_reset", 32'(resp_valid), 32'd0);
        end
        reset = 1'b0;
        req_valid = 1'b0;
        chk("rst_wait ready_after", 32'(req_ready), 32'd1);
        for (int i = 0; i < LAT + 1; i++) begin
            chk("rst_wait no_pulse", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        op(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 0, "rst_wait store_kept");
        chk("rst_wait store_kept const", last_rd, 32'hCAFEF00D);
        op(1'b0, 2'b10, 1'b0, 32'h84, 32'd0, 0, "rst_wait req_during_reset_dropped");

        for (int i = 0; i < 300; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            r  = $urandom_range(0, 9);
            if (r < 7) begin
                a = 32'($urandom_range(0, DEPTH - 1));
                if (r < 5) a = a & ~32'(nb - 1);
            end else if (r == 7) begin
                a = $urandom;
            end else begin
                a = 32'(DEPTH - 4 + $urandom_range(0, 3));
            end
            op(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 2), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
